// File: rtl/microseq_control_unit.sv
// Table-driven microsequencer: START, FETCH and per-opcode EXEC routines come from a writable
// microcode store. Define STEP_MODE_EN to add the single-step PAUSE state and the step_req input.
module microseq_control_unit #(
    parameter int unsigned OPC_W      = 8,
    parameter int unsigned CS_W       = 34,
    parameter int unsigned MAX_STEPS  = 4,
    parameter int unsigned GLOBAL_MAX = 7,
    parameter int unsigned COND_A     = 38,
    parameter int unsigned COND_B     = 40,
    parameter int unsigned START_OPC  = 254,
    parameter int unsigned FETCH_OPC  = 255
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [OPC_W-1:0]                   ins,
    input  logic                               z,
    input  logic                               xc,
`ifdef STEP_MODE_EN
    input  logic                               step_req,
`endif
    input  logic                               uc_we,
    input  logic [OPC_W+$clog2(MAX_STEPS)-1:0] uc_addr,
    input  logic [CS_W:0]                      uc_wdata,
    output logic                               uc_err,
    output logic [CS_W-1:0]                    control_signal,
    output logic                               end_process,
    output logic                               busy,
    output logic                               illegal
);
    localparam int unsigned STEP_W  = $clog2(MAX_STEPS);
    localparam int unsigned ADDR_W  = OPC_W + STEP_W;
    localparam int unsigned NUM_OPC = 2 ** OPC_W;

    localparam logic [OPC_W-1:0]  StartOpc  = OPC_W'(START_OPC);
    localparam logic [OPC_W-1:0]  FetchOpc  = OPC_W'(FETCH_OPC);
    localparam logic [OPC_W-1:0]  GlobalMax = OPC_W'(GLOBAL_MAX);
    localparam logic [OPC_W-1:0]  CondA     = OPC_W'(COND_A);
    localparam logic [OPC_W-1:0]  CondB     = OPC_W'(COND_B);
    localparam logic [STEP_W-1:0] LastStep  = STEP_W'(MAX_STEPS - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StFetch = 3'd2;
    localparam logic [2:0] StExec  = 3'd3;
    localparam logic [2:0] StHalt  = 3'd4;
`ifdef STEP_MODE_EN
    localparam logic [2:0] StPause = 3'd5;
`endif

    logic [CS_W:0]        store [2**ADDR_W];
    logic [NUM_OPC-1:0]   valid_q;
    logic [2:0]           state_q, state_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [OPC_W-1:0]     eff_q, eff_d;
    logic                 nop_q, nop_d;
    logic                 illegal_q, illegal_d;
    logic                 uc_err_q;
    logic                 rearm_q, rearm_d;

    logic [OPC_W-1:0]     cur_opc;
    logic [CS_W:0]        rd_word;
    logic                 routine_end;
    logic [OPC_W-1:0]     ins_eff;
    logic                 gated;
    logic                 wr_ok;

    assign busy        = (state_q == StStart) || (state_q == StFetch) || (state_q == StExec)
`ifdef STEP_MODE_EN
                         || (state_q == StPause)
`endif
                         ;
    assign end_process = (state_q == StHalt);
    assign illegal     = illegal_q;
    assign uc_err      = uc_err_q;
    assign wr_ok       = uc_we && !busy;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            store[uc_addr] <= uc_wdata;
        end
    end

    always_comb begin
        case (state_q)
            StStart: cur_opc = StartOpc;
            StFetch: cur_opc = FetchOpc;
            default: cur_opc = eff_q;
        endcase
    end

    assign rd_word     = store[{cur_opc, step_q}];
    assign routine_end = rd_word[CS_W] || (step_q == LastStep);

    // Core gating only applies above the global range; conditionals pick the pair member via z.
    always_comb begin
        ins_eff = ins;
        gated   = 1'b0;
        if (ins > GlobalMax) begin
            if (!xc) begin
                gated = 1'b1;
            end else if ((ins == CondA) || (ins == CondB)) begin
                ins_eff = ins + OPC_W'(z);
            end
        end
    end

    always_comb begin
        control_signal = '0;
        if ((state_q == StStart) || (state_q == StFetch) || ((state_q == StExec) && !nop_q)) begin
            control_signal = rd_word[CS_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        eff_d     = eff_q;
        nop_d     = nop_q;
        illegal_d = 1'b0;
        rearm_d   = rearm_q;
        case (state_q)
            StIdle: begin
                step_d = '0;
                if (start) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (routine_end) begin
                    state_d = StFetch;
                    step_d  = '0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            StFetch: begin
                if (routine_end) begin
                    state_d   = StExec;
                    step_d    = '0;
                    eff_d     = ins_eff;
                    nop_d     = gated || !valid_q[ins_eff];
                    illegal_d = !gated && !valid_q[ins_eff];
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            StExec: begin
                if (nop_q || routine_end) begin
                    step_d = '0;
                    if (!nop_q && (eff_q == CondA)) begin
                        state_d = StHalt;
                        rearm_d = 1'b0;
                    end else begin
`ifdef STEP_MODE_EN
                        state_d = StPause;
`else
                        state_d = StFetch;
`endif
                    end
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            StHalt: begin
                // A start level held on HALT entry must drop before it can restart.
                if (!start) begin
                    rearm_d = 1'b1;
                end else if (rearm_q) begin
                    state_d = StStart;
                end
            end
`ifdef STEP_MODE_EN
            StPause: begin
                if (step_req) begin
                    state_d = StFetch;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            step_q    <= '0;
            eff_q     <= '0;
            nop_q     <= 1'b0;
            illegal_q <= 1'b0;
            uc_err_q  <= 1'b0;
            rearm_q   <= 1'b0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            eff_q     <= eff_d;
            nop_q     <= nop_d;
            illegal_q <= illegal_d;
            uc_err_q  <= uc_we && busy;
            rearm_q   <= rearm_d;
            if (wr_ok) begin
                valid_q[uc_addr[ADDR_W-1:STEP_W]] <= 1'b1;
            end
        end
    end
endmodule
